sync_fifo: RTL and testbench

- Single-clock, first-word-fall-through FIFO buffering DATA_WIDTH-bit words between a producer and a consumer in the same clock domain.
- Sits between a packet source, which writes bursts (for example 10-byte packets), and a slower consumer that drains at its own pace.
- Provides FULL and EMPTY back-pressure flags.
- Storage is a dual-port register array held in a separate memory submodule, with pointer and flag logic in the top level.

---
 rtl/sync_fifo.sv | 90 +++++++++
 tb/tb_sync_fifo.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock first-word-fall-through FIFO with FULL/EMPTY flags
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Storage is deliberately not reset; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];
endmodule

module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  W_INC,
   input  logic [DATA_WIDTH-1:0] WR_DATA,
   output logic                  FULL,
   input  logic                  R_INC,
   output logic [DATA_WIDTH-1:0] RD_DATA,
   output logic                  EMPTY
);
   localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // Extra MSB distinguishes full from empty when the address bits match.
   assign EMPTY = (wr_ptr == rd_ptr);
   assign FULL  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                  (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

   assign wr_en = W_INC && !FULL;
   assign rd_en = R_INC && !EMPTY;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk   (CLK),
      .we    (wr_en),
      .waddr (wr_ptr[ADDR_WIDTH-1:0]),
      .wdata (WR_DATA),
      .raddr (rd_ptr[ADDR_WIDTH-1:0]),
      .rdata (mem_rdata)
   );

   assign RD_DATA = EMPTY ? '0 : mem_rdata;
endmodule

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// ============================================================================
// tb_sync_fifo : directed vector table plus queue-model sequences for sync_fifo
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo;
   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       W_INC = 1'b0;
   logic [7:0] WR_DATA = 8'h00;
   logic       FULL;
   logic       R_INC = 1'b0;
   logic [7:0] RD_DATA;
   logic       EMPTY;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] q[$];

   typedef struct {
      string      name;
      logic       w;
      logic [7:0] d;
      logic       r;
      logic [7:0] exp_rd;
      logic       exp_empty;
      logic       exp_full;
   } vec_t;

   vec_t vecs[8];

   sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .W_INC   (W_INC),
      .WR_DATA (WR_DATA),
      .FULL    (FULL),
      .R_INC   (R_INC),
      .RD_DATA (RD_DATA),
      .EMPTY   (EMPTY)
   );

   always #5 CLK = ~CLK;

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_model(input string name);
      cmp({name, "_rd"},    RD_DATA, (q.size() > 0) ? q[0] : 8'h00);
      cmp({name, "_empty"}, {7'd0, EMPTY}, {7'd0, q.size() == 0});
      cmp({name, "_full"},  {7'd0, FULL},  {7'd0, q.size() == 16});
   endtask

   // One clock edge with the given inputs; the model updates from pre-edge occupancy.
   task automatic step(input logic w, input logic [7:0] d, input logic r);
      bit do_w, do_r;
      @(negedge CLK);
      W_INC = w; WR_DATA = d; R_INC = r;
      do_w = w && (q.size() < 16);
      do_r = r && (q.size() > 0);
      @(posedge CLK);
      #1;
      if (do_r) void'(q.pop_front());
      if (do_w) q.push_back(d);
      W_INC = 1'b0; R_INC = 1'b0;
   endtask

   initial begin
      vecs[0] = '{"empty_pop0", 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[1] = '{"empty_pop1", 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{"empty_pop2", 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[3] = '{"write_a5",   1'b1, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0};
      vecs[4] = '{"wr_rd_3c",   1'b1, 8'h3C, 1'b1, 8'h3C, 1'b0, 1'b0};
      vecs[5] = '{"pop_3c",     1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[6] = '{"empty_wr_rd",1'b1, 8'h77, 1'b1, 8'h77, 1'b0, 1'b0};
      vecs[7] = '{"pop_77",     1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};

      // Reset state
      #12;
      cmp("reset_empty", {7'd0, EMPTY}, 8'd1);
      cmp("reset_full",  {7'd0, FULL},  8'd0);
      cmp("reset_rd",    RD_DATA,       8'h00);
      @(negedge CLK);
      RST = 1'b1;

      // Hand-computed vector table
      for (int i = 0; i < 8; i++) begin
         step(vecs[i].w, vecs[i].d, vecs[i].r);
         cmp({vecs[i].name, "_rd"},    RD_DATA,          vecs[i].exp_rd);
         cmp({vecs[i].name, "_empty"}, {7'd0, EMPTY},    {7'd0, vecs[i].exp_empty});
         cmp({vecs[i].name, "_full"},  {7'd0, FULL},     {7'd0, vecs[i].exp_full});
      end

      // Packet burst with a slower consumer (two pops per five cycles)
      begin
         logic [7:0] pkt [10];
         int pops = 0;
         int cyc  = 0;
         pkt = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12, 8'h01, 8'h0D};
         while ((cyc < 10 || q.size() > 0) && cyc < 100) begin
            logic w, r;
            w = (cyc < 10);
            r = ((cyc % 5 == 1) || (cyc % 5 == 3)) && (q.size() > 0);
            if (r) begin
               cmp("burst_order", RD_DATA, pkt[pops]);
               pops++;
            end
            step(w, w ? pkt[cyc] : 8'h00, r);
            check_model("burst");
            cyc++;
         end
         cmp("burst_pops", 8'(pops), 8'd10);
         cmp("burst_end_empty", {7'd0, EMPTY}, 8'd1);
      end

      // Fill to full, overflow write ignored, drain in order
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
      cmp("fill_full", {7'd0, FULL}, 8'd1);
      step(1'b1, 8'hFF, 1'b0);
      cmp("overflow_full", {7'd0, FULL}, 8'd1);
      cmp("overflow_head", RD_DATA, 8'h00);
      for (int i = 0; i < 16; i++) begin
         cmp("drain_val", RD_DATA, 8'(i));
         step(1'b0, 8'h00, 1'b1);
         check_model("drain");
      end
      cmp("drain_empty", {7'd0, EMPTY}, 8'd1);

      // Occupancy-1 streaming across address wrap
      step(1'b1, 8'h40, 1'b0);
      for (int i = 1; i <= 40; i++) begin
         cmp("wrap_head", RD_DATA, 8'(8'h40 + i - 1));
         step(1'b1, 8'(8'h40 + i), 1'b1);
         check_model("wrap");
      end
      cmp("wrap_last", RD_DATA, 8'h68);
      step(1'b0, 8'h00, 1'b1);
      check_model("wrap_end");

      // Simultaneous write and read while full
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
      check_model("full2");
      step(1'b1, 8'hEE, 1'b1);
      cmp("full_rw_full", {7'd0, FULL}, 8'd0);
      cmp("full_rw_head", RD_DATA, 8'h81);
      for (int i = 1; i < 16; i++) begin
         cmp("full_rw_val", RD_DATA, 8'(8'h80 + i));
         step(1'b0, 8'h00, 1'b1);
      end
      cmp("full_rw_empty", {7'd0, EMPTY}, 8'd1);

      // Asynchronous reset mid-operation
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
      check_model("pre_reset");
      @(negedge CLK);
      #2;
      RST = 1'b0;
      #1;
      q.delete();
      cmp("async_rst_empty", {7'd0, EMPTY}, 8'd1);
      cmp("async_rst_full",  {7'd0, FULL},  8'd0);
      cmp("async_rst_rd",    RD_DATA,       8'h00);
      #1;
      RST = 1'b1;
      step(1'b1, 8'h5A, 1'b0);
      cmp("post_rst_rd", RD_DATA, 8'h5A);
      cmp("post_rst_empty", {7'd0, EMPTY}, 8'd0);
      step(1'b0, 8'h00, 1'b1);
      check_model("post_rst_pop");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule

`default_nettype wire
